// File: rtl/tick_pkg.sv
// tick_pkg: shared timebase constants and divisor packing helper for tick_cascade.
package tick_pkg;
  localparam int CLK_HZ = 12_000_000;
  localparam logic [15:0] DIV0_DEF = 16'd15;
  localparam logic [15:0] DIV1_DEF = 16'd6667;
  localparam logic [15:0] DIV2_DEF = 16'd120;
  function automatic logic [47:0] pack_div3(input logic [15:0] d0, input logic [15:0] d1,
                                            input logic [15:0] d2);
    return {d2, d1, d0};
  endfunction
  localparam logic [47:0] DIV_INIT_DEF = pack_div3(DIV0_DEF, DIV1_DEF, DIV2_DEF);
endpackage

// File: rtl/tick_stage.sv
// tick_stage: one prescaler stage with shadowed divisor applied at wrap or clear.
module tick_stage
  import tick_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] INIT = '1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_adv,
  input  logic             i_clear,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_data,
  output logic             o_term,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_cnt, r_div, r_shadow;
  logic             r_pend, r_tick;
  logic             w_apply;
  assign o_term  = i_adv & (r_cnt == r_div - CNT_W'(1));
  // a same-cycle write lands in the shadow only; the older shadow is what gets applied
  assign w_apply = r_pend & (o_term | i_clear);
  assign o_tick  = r_tick;
  assign o_count = r_cnt;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_div    <= INIT;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_cnt    <= (i_clear | o_term) ? '0 : i_adv ? r_cnt + CNT_W'(1) : r_cnt;
      r_div    <= w_apply ? r_shadow : r_div;
      r_shadow <= i_wr ? i_data : r_shadow;
      r_pend   <= i_wr | (r_pend & ~w_apply);
      r_tick   <= o_term;
    end
  end
endmodule

// File: rtl/tick_cascade.sv
// tick_cascade: chained prescaler stages producing aligned single-cycle tick strobes.
module tick_cascade
  import tick_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CNT_W = 16,
  parameter logic [STAGES*CNT_W-1:0] DIV_INIT = DIV_INIT_DEF,
  parameter int SEL_W = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_clear,
  input  logic                    i_div_wr,
  input  logic [SEL_W-1:0]        i_div_sel,
  input  logic [CNT_W-1:0]        i_div_data,
  output logic [STAGES-1:0]       o_tick,
  output logic [STAGES*CNT_W-1:0] o_count,
  output logic                    o_div_err
);
  logic [STAGES-1:0] w_adv, w_term;
  logic              w_bad, r_err;
  assign w_bad     = i_div_wr & ((i_div_data == '0) | (32'(i_div_sel) >= STAGES));
  assign o_div_err = r_err;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_err <= 1'b0;
    else r_err <= w_bad;
  end
  // stages advance on the previous stage's combinational term so coincident ticks stay aligned
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign w_adv[g] = i_enable & ~i_clear;
    end else begin : g_chain
      assign w_adv[g] = w_term[g-1];
    end
    tick_stage #(
      .CNT_W(CNT_W),
      .INIT (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_stage (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_adv  (w_adv[g]),
      .i_clear(i_clear),
      .i_wr   (i_div_wr & ~w_bad & (i_div_sel == SEL_W'(g))),
      .i_data (i_div_data),
      .o_term (w_term[g]),
      .o_tick (o_tick[g]),
      .o_count(o_count[g*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_tick_cascade.sv
// tb_tick_cascade: randomized and directed checks of tick_cascade against a mixed-radix counter model.
module tb_tick_cascade;
  localparam int S = 3;
  localparam int W = 4;
  localparam int SW = 3;
  logic i_clk = 1'b0;
  logic i_reset, i_enable, i_clear, i_div_wr;
  logic [SW-1:0] i_div_sel;
  logic [W-1:0] i_div_data;
  logic [S-1:0] o_tick;
  logic [S*W-1:0] o_count;
  logic o_div_err;
  int n_pass = 0;
  int n_total = 0;
  int m_cnt[S], m_div[S], m_sh[S];
  bit m_pend[S];
  logic [S-1:0] m_tick;
  logic m_err;

  tick_cascade #(.STAGES(S), .CNT_W(W), .DIV_INIT(12'h423), .SEL_W(SW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
    .i_div_wr(i_div_wr), .i_div_sel(i_div_sel), .i_div_data(i_div_data),
    .o_tick(o_tick), .o_count(o_count), .o_div_err(o_div_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [S*W-1:0] m_count();
    logic [S*W-1:0] v;
    for (int k = 0; k < S; k++) v[k*W +: W] = W'(m_cnt[k]);
    return v;
  endfunction

  task automatic model_reset();
    m_div = '{3, 2, 4};
    m_cnt = '{0, 0, 0};
    m_sh = '{0, 0, 0};
    m_pend = '{0, 0, 0};
    m_tick = '0;
    m_err = 1'b0;
  endtask

  // counts behave as a mixed-radix number whose digit k has radix div[k]
  task automatic model_step(input bit en, input bit clr, input bit wr, input int sel, input int data);
    bit carry;
    carry = en;
    m_tick = '0;
    m_err = wr && (data == 0 || sel >= S);
    for (int k = 0; k < S; k++) begin
      if (clr) begin
        m_cnt[k] = 0;
        if (m_pend[k]) begin m_div[k] = m_sh[k]; m_pend[k] = 0; end
      end else if (carry) begin
        if (m_cnt[k] + 1 == m_div[k]) begin
          m_cnt[k] = 0;
          m_tick[k] = 1'b1;
          if (m_pend[k]) begin m_div[k] = m_sh[k]; m_pend[k] = 0; end
        end else begin
          m_cnt[k]++;
          carry = 0;
        end
      end
    end
    if (wr && !m_err) begin m_sh[sel] = data; m_pend[sel] = 1; end
  endtask

  task automatic step(input bit en, input bit clr, input bit wr, input int sel, input int data);
    i_enable = en;
    i_clear = clr;
    i_div_wr = wr;
    i_div_sel = SW'(sel);
    i_div_data = W'(data);
    @(posedge i_clk);
    model_step(en, clr, wr, sel, data);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_clear = 1'b0; i_div_wr = 1'b0; i_div_sel = '0; i_div_data = '0;
    model_reset();
    #1;
    n_total++;
    if (o_tick !== 3'b000) $display("FAIL reset_tick: got %b want 000", o_tick); else n_pass++;
    n_total++;
    if (o_count !== 12'h000) $display("FAIL reset_count: got %h want 000", o_count); else n_pass++;
    n_total++;
    if (o_div_err !== 1'b0) $display("FAIL reset_err: got %b want 0", o_div_err); else n_pass++;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
  endtask

  task automatic test_periods();
    int n0 = 0, n1 = 0, n2 = 0, first0 = -1, skew = 0;
    for (int i = 1; i <= 48; i++) begin
      step(1, 0, 0, 0, 1);
      n_total++;
      if ({o_tick, o_count, o_div_err} !== {m_tick, m_count(), m_err})
        $display("FAIL periods_cyc%0d: got tick=%b count=%h err=%b want tick=%b count=%h err=%b",
                 i, o_tick, o_count, o_div_err, m_tick, m_count(), m_err);
      else n_pass++;
      if (o_tick[0]) begin n0++; if (first0 < 0) first0 = i; end
      if (o_tick[1]) n1++;
      if (o_tick[2]) n2++;
      if ((o_tick[1] && !o_tick[0]) || (o_tick[2] && o_tick[1:0] != 2'b11)) skew++;
    end
    n_total++;
    if (first0 !== 3) $display("FAIL first_tick0: got edge %0d want 3", first0); else n_pass++;
    n_total++;
    if (n0 !== 16) $display("FAIL tick0_count: got %0d want 16", n0); else n_pass++;
    n_total++;
    if (n1 !== 8) $display("FAIL tick1_count: got %0d want 8", n1); else n_pass++;
    n_total++;
    if (n2 !== 2) $display("FAIL tick2_count: got %0d want 2", n2); else n_pass++;
    n_total++;
    if (skew !== 0) $display("FAIL tick_alignment: got %0d misaligned want 0", skew); else n_pass++;
  endtask

  task automatic test_freeze();
    logic [S*W-1:0] saved;
    step(1, 0, 0, 0, 1);
    saved = o_count;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1);
      n_total++;
      if (o_tick !== 3'b000 || o_count !== saved)
        $display("FAIL freeze_cyc%0d: got tick=%b count=%h want tick=000 count=%h", i, o_tick, o_count, saved);
      else n_pass++;
    end
    step(1, 0, 0, 0, 1);
    n_total++;
    if (o_tick[0] !== 1'b0) $display("FAIL resume_early: got tick0=%b want 0", o_tick[0]); else n_pass++;
    step(1, 0, 0, 0, 1);
    n_total++;
    if (o_tick[0] !== 1'b1) $display("FAIL resume_tick: got tick0=%b want 1", o_tick[0]); else n_pass++;
  endtask

  task automatic test_div_write();
    int t[$];
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 5);
    for (int j = 1; j <= 16; j++) begin
      step(1, 0, 0, 0, 1);
      n_total++;
      if ({o_tick, o_count, o_div_err} !== {m_tick, m_count(), m_err})
        $display("FAIL divwr_cyc%0d: got tick=%b count=%h err=%b want tick=%b count=%h err=%b",
                 j, o_tick, o_count, o_div_err, m_tick, m_count(), m_err);
      else n_pass++;
      if (o_tick[0]) t.push_back(j);
    end
    n_total++;
    if (t.size() < 3 || t[0] != 1 || t[1] - t[0] != 5 || t[2] - t[1] != 5)
      $display("FAIL divwr_spacing: got %0d ticks first=%0d want first=1 spacing=5", t.size(),
               t.size() > 0 ? t[0] : -1);
    else n_pass++;
  endtask

  task automatic test_div_reject();
    int sel_t[4] = '{1, 0, 3, 0};
    int dat_t[4] = '{0, 1, 2, 1};
    bit wr_t[4] = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      step(1, 0, wr_t[i], sel_t[i], dat_t[i]);
      n_total++;
      if (o_div_err !== logic'(wr_t[i])) $display("FAIL reject%0d_err: got %b want %b", i, o_div_err, wr_t[i]);
      else n_pass++;
      n_total++;
      if ({o_tick, o_count} !== {m_tick, m_count()})
        $display("FAIL reject%0d_state: got tick=%b count=%h want tick=%b count=%h", i, o_tick, o_count, m_tick, m_count());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int n2 = 0;
    step(1, 0, 1, 2, 7);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    #2 i_reset = 1'b1;
    #1;
    n_total++;
    if ({o_tick, o_count, o_div_err} !== 16'h0000)
      $display("FAIL async_reset: got tick=%b count=%h err=%b want all zero", o_tick, o_count, o_div_err);
    else n_pass++;
    model_reset();
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      step(1, 0, 0, 0, 1);
      n_total++;
      if ({o_tick, o_count, o_div_err} !== {m_tick, m_count(), m_err})
        $display("FAIL postreset_cyc%0d: got tick=%b count=%h want tick=%b count=%h", i, o_tick, o_count, m_tick, m_count());
      else n_pass++;
      if (o_tick[2]) n2++;
    end
    n_total++;
    if (n2 !== 2) $display("FAIL postreset_tick2: got %0d want 2", n2); else n_pass++;
  endtask

  task automatic test_clear();
    int t[$];
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 1, 4);
    step(1, 1, 0, 0, 1);
    n_total++;
    if (o_count !== 12'h000 || o_tick !== 3'b000)
      $display("FAIL clear: got tick=%b count=%h want tick=000 count=000", o_tick, o_count);
    else n_pass++;
    for (int j = 1; j <= 40; j++) begin
      step(1, 0, 0, 0, 1);
      n_total++;
      if ({o_tick, o_count, o_div_err} !== {m_tick, m_count(), m_err})
        $display("FAIL clear_cyc%0d: got tick=%b count=%h want tick=%b count=%h", j, o_tick, o_count, m_tick, m_count());
      else n_pass++;
      if (o_tick[1]) t.push_back(j);
    end
    n_total++;
    if (t.size() < 2 || t[0] != 12 || t[1] - t[0] != 12)
      $display("FAIL clear_period1: got %0d ticks first=%0d want first=12 period=12", t.size(), t.size() > 0 ? t[0] : -1);
    else n_pass++;
  endtask

  task automatic test_random();
    bit en, clr, wr;
    int sel, data;
    for (int i = 0; i < 600; i++) begin
      en = $urandom_range(0, 9) != 0;
      clr = $urandom_range(0, 59) == 0;
      wr = $urandom_range(0, 7) == 0;
      sel = $urandom_range(0, 4);
      data = $urandom_range(0, 15);
      step(en, clr, wr, sel, data);
      n_total++;
      if ({o_tick, o_count, o_div_err} !== {m_tick, m_count(), m_err})
        $display("FAIL random_cyc%0d: got tick=%b count=%h err=%b want tick=%b count=%h err=%b",
                 i, o_tick, o_count, o_div_err, m_tick, m_count(), m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_periods();
    test_freeze();
    test_div_write();
    test_div_reject();
    test_async_reset();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
